// File: rtl/mult_sched_pkg.sv
// Shared widths, the id-width helper and the stage-1 record used by the
// shared 8x8 multiplier scheduler.
package mult_sched_pkg;

   localparam int OP_W     = 8;
   localparam int PROD_W   = 16;
   // Requester count never exceeds 8, so a 3-bit id field covers every build.
   localparam int MAX_ID_W = 3;

   function automatic int ID_W(input int num_req);
      return $clog2(num_req);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
      logic [OP_W-1:0]     a;
      logic [OP_W-1:0]     b;
   } s1_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester found when
// searching upward from ptr+1 (wrapping), producing a one-hot grant and
// the matching binary index.
module rr_arbiter
   import mult_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_BITS = ID_W(NUM_REQ)
)
(
   input  logic [NUM_REQ-1:0] elig,
   input  logic [ID_BITS-1:0] ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_BITS-1:0] grant_idx
);

   // Rotating priority search; the first hit after ptr wins.
   always_comb begin
      logic               found;
      logic [ID_BITS-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_BITS'((int'(ptr) + k) % NUM_REQ);
         if (!found && elig[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/russian_peasant_modified_unsigned_multiplier_8.sv
// Combinational 8x8 unsigned multiplier built as an unrolled
// halve-and-double (Russian peasant) shift-add; full 16-bit product.
module russian_peasant_modified_unsigned_multiplier_8 (
   output logic [15:0] product,
   input  logic [7:0]  A,
   input  logic [7:0]  B
);

   // Add the doubled multiplicand whenever the halved multiplier is odd.
   always_comb begin
      logic [15:0] acc;
      logic [15:0] dbl;
      logic [7:0]  half;
      acc  = '0;
      dbl  = {8'd0, A};
      half = B;
      for (int k = 0; k < 8; k++) begin
         if (half[0]) begin
            acc = acc + dbl;
         end
         dbl  = dbl << 1;
         half = half >> 1;
      end
      product = acc;
   end

endmodule

// File: rtl/mult8_rr_scheduler.sv
// Shares one combinational 8x8 multiplier among NUM_REQ requesters with
// round-robin arbitration, one transaction in flight per requester, an
// operand register in front of the multiplier and per-requester response
// registers behind it.
module mult8_rr_scheduler
   import mult_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [OP_W*NUM_REQ-1:0]    req_a,
   input  logic [OP_W*NUM_REQ-1:0]    req_b,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [PROD_W*NUM_REQ-1:0]  rsp_product,
   output logic                       busy
);

   localparam int IW = ID_W(NUM_REQ);

   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] rsp_fire;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      grant_idx;
   logic [OP_W-1:0]    sel_a;
   logic [OP_W-1:0]    sel_b;
   logic [PROD_W-1:0]  product;
   s1_rec_t            s1;

   // Only registered pending gates eligibility, so a response handshake
   // and a new accept for the same requester never share a cycle.
   assign elig     = req_valid & ~pending;
   assign rsp_fire = rsp_valid & rsp_ready;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_BITS (IW)
   ) u_arb (
      .elig      (elig),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Ready is masked while reset is held so nothing looks accepted then.
   assign req_ready = grant & {NUM_REQ{rst_n}};
   assign busy      = s1.valid | (|pending);

   // Select the granted requester's operands for the stage-1 register.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_a = sel_a | req_a[OP_W*i +: OP_W];
            sel_b = sel_b | req_b[OP_W*i +: OP_W];
         end
      end
   end

   russian_peasant_modified_unsigned_multiplier_8 u_mult (
      .product (product),
      .A       (s1.a),
      .B       (s1.b)
   );

   // Stage-1 operand register and round-robin pointer; ptr moves only on
   // a grant so requester 0 leads after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= IW'(NUM_REQ - 1);
         s1  <= '0;
      end else if (|req_ready) begin
         ptr      <= grant_idx;
         s1.valid <= 1'b1;
         s1.id    <= MAX_ID_W'(grant_idx);
         s1.a     <= sel_a;
         s1.b     <= sel_b;
      end else begin
         s1.valid <= 1'b0;
      end
   end

   // Per-requester in-flight flag, response flag and held product; the
   // product register keeps its value after the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= '0;
         rsp_valid   <= '0;
         rsp_product <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
               pending[i] <= 1'b1;
            end else if (rsp_fire[i]) begin
               pending[i] <= 1'b0;
            end
            if (s1.valid && (s1.id == MAX_ID_W'(i))) begin
               rsp_valid[i]                      <= 1'b1;
               rsp_product[PROD_W*i +: PROD_W]   <= product;
            end else if (rsp_fire[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mult8_rr_scheduler.sv
// Self-checking bench for mult8_rr_scheduler: directed steps plus a random
// soak, with a scoreboard queue filled on accept and drained on response.
module tb_mult8_rr_scheduler;

   localparam int N = 4;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [8*N-1:0]  req_a;
   logic [8*N-1:0]  req_b;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [16*N-1:0] rsp_product;
   logic            busy;

   typedef struct {
      int          id;
      logic [15:0] prod;
   } sb_t;

   sb_t          sb[$];
   logic [N-1:0] inflight;
   int           wait_cnt [N];
   int           n_checks;
   int           n_fail;

   mult8_rr_scheduler #(.NUM_REQ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_product (rsp_product),
      .busy        (busy)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b);
      req_a[8*id +: 8] = a;
      req_b[8*id +: 8] = b;
      req_valid[id]    = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '1;
      #1;
      checkOutput("rst_req_ready", 32'(req_ready), 0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_product_zero", 32'(rsp_product == '0), 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Scoreboard and protocol monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         inflight = '0;
         for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end else begin
         logic [N-1:0] elig_m;
         int           hit;
         sb_t          e;
         elig_m = req_valid & ~inflight;
         checkOutput("mon_onehot", 32'($onehot0(req_ready)), 1);
         checkOutput("mon_grant_eligible", 32'(req_ready & ~elig_m), 0);
         checkOutput("mon_work_conserving", 32'(elig_m != 0), 32'(req_ready != 0));
         checkOutput("mon_rsp_spurious", 32'(rsp_valid & ~inflight), 0);
         for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               hit = -1;
               for (int k = 0; k < sb.size(); k++) begin
                  if (sb[k].id == i && hit < 0) hit = k;
               end
               checkOutput($sformatf("mon_rsp_expected_%0d", i), 32'(hit >= 0), 1);
               if (hit >= 0) begin
                  checkOutput($sformatf("mon_product_%0d", i),
                              32'(rsp_product[16*i +: 16]), 32'(sb[hit].prod));
                  sb.delete(hit);
               end
               inflight[i] = 1'b0;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               checkOutput($sformatf("mon_single_inflight_%0d", i), 32'(inflight[i]), 0);
               checkOutput($sformatf("mon_starvation_%0d", i), 32'(wait_cnt[i] < N), 1);
               e.id   = i;
               e.prod = 16'(req_a[8*i +: 8]) * 16'(req_b[8*i +: 8]);
               sb.push_back(e);
               inflight[i] = 1'b1;
               wait_cnt[i] = 0;
            end else if (elig_m[i] && (req_ready != 0)) begin
               wait_cnt[i]++;
            end else if (!elig_m[i]) begin
               wait_cnt[i] = 0;
            end
         end
      end
   end

   // Directed steps followed by the random soak.
   initial begin
      logic [N-1:0] acc;
      logic [7:0]   ca [3];
      logic [7:0]   cb [3];
      logic [15:0]  cp [3];
      int           served;

      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '1;
      #2;

      $display("[TB] single transaction");
      resetDut();
      applyStimulus(0, 8'hFF, 8'hFF);
      @(negedge clk);
      checkOutput("t1_ready", 32'(req_ready), 32'h1);
      checkOutput("t1_busy_idle", 32'(busy), 0);
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      checkOutput("t1_rsp_not_yet", 32'(rsp_valid), 0);
      checkOutput("t1_busy_s1", 32'(busy), 1);
      tick();
      @(negedge clk);
      checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("t1_product", 32'(rsp_product[15:0]), 32'hFE01);
      checkOutput("t1_busy_rsp", 32'(busy), 1);
      tick();
      @(negedge clk);
      checkOutput("t1_rsp_consumed", 32'(rsp_valid), 0);
      checkOutput("t1_busy_fall", 32'(busy), 0);
      checkOutput("t1_product_held", 32'(rsp_product[15:0]), 32'hFE01);

      $display("[TB] round-robin");
      resetDut();
      for (int i = 0; i < N; i++) applyStimulus(i, 8'(i + 1), 8'h10);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t2_ready_%0d", k), 32'(req_ready),
                     (k < 4) ? (32'h1 << k) : 32'h0);
         checkOutput($sformatf("t2_rsp_valid_%0d", k), 32'(rsp_valid),
                     (k >= 2) ? (32'h1 << (k - 2)) : 32'h0);
         if (k >= 2) begin
            checkOutput($sformatf("t2_product_%0d", k - 2),
                        32'(rsp_product[16*(k-2) +: 16]), 32'(16 * (k - 1)));
         end
         tick();
         if (k < 4) req_valid[k] = 1'b0;
      end

      $display("[TB] back-pressure");
      resetDut();
      rsp_ready = 4'b1101;
      applyStimulus(1, 8'd3, 8'd5);
      applyStimulus(2, 8'h11, 8'h11);
      applyStimulus(3, 8'h22, 8'h02);
      @(negedge clk);
      checkOutput("t3_first_grant", 32'(req_ready), 32'h2);
      tick();
      applyStimulus(1, 8'd7, 8'd9);
      served = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("t3_no_regrant", 32'(req_ready[1]), 0);
         checkOutput("t3_rsp1_valid", 32'(rsp_valid[1]), 32'(c >= 1));
         if (c >= 1) checkOutput("t3_rsp1_stable", 32'(rsp_product[31:16]), 32'd15);
         acc = req_valid & req_ready;
         if (acc[2]) served++;
         if (acc[3]) served++;
         tick();
         if (acc[2]) applyStimulus(2, 8'(c + 1), 8'h03);
         if (acc[3]) applyStimulus(3, 8'h10, 8'(c));
      end
      checkOutput("t3_others_served", 32'(served >= 6), 1);
      req_valid[2] = 1'b0;
      req_valid[3] = 1'b0;
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      checkOutput("t3_rsp1_handshake", 32'(rsp_valid[1]), 1);
      checkOutput("t3_no_same_cycle_accept", 32'(req_ready), 0);
      tick();
      @(negedge clk);
      checkOutput("t3_reaccept", 32'(req_ready), 32'h2);
      tick();
      req_valid[1] = 1'b0;
      repeat (4) tick();

      $display("[TB] corner operands");
      resetDut();
      ca[0] = 8'h00; cb[0] = 8'hAB; cp[0] = 16'h0000;
      ca[1] = 8'h80; cb[1] = 8'h02; cp[1] = 16'h0100;
      ca[2] = 8'h01; cb[2] = 8'hFF; cp[2] = 16'h00FF;
      for (int i = 0; i < 3; i++) applyStimulus(i, ca[i], cb[i]);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k < 3) checkOutput($sformatf("t4_ready_%0d", k), 32'(req_ready), 32'h1 << k);
         if (k >= 2) begin
            checkOutput($sformatf("t4_product_%0d", k - 2),
                        32'(rsp_product[16*(k-2) +: 16]), 32'(cp[k-2]));
         end
         tick();
         if (k < 3) req_valid[k] = 1'b0;
      end

      $display("[TB] reset mid-flight");
      resetDut();
      applyStimulus(0, 8'd5, 8'd6);
      @(negedge clk);
      checkOutput("t5_accept", 32'(req_ready), 32'h1);
      tick();
      rst_n = 1'b0;
      req_valid[0] = 1'b0;
      applyStimulus(1, 8'd2, 8'd3);
      applyStimulus(3, 8'd4, 8'd5);
      #1;
      checkOutput("t5_rst_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("t5_rst_busy", 32'(busy), 0);
      checkOutput("t5_rst_ready", 32'(req_ready), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t5_first_grant", 32'(req_ready), 32'h2);
      checkOutput("t5_no_rsp", 32'(rsp_valid), 0);
      tick();
      req_valid[1] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("t5_no_stale_rsp", 32'(rsp_valid[0]), 0);
         tick();
      end
      req_valid = '0;
      repeat (4) tick();

      $display("[TB] random soak");
      resetDut();
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         tick();
         for (int i = 0; i < N; i++) begin
            if (acc[i] || !req_valid[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  applyStimulus(i, 8'($urandom), 8'($urandom));
               end else begin
                  req_valid[i] = 1'b0;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
            rsp_ready[i] = ($urandom_range(0, 3) != 0);
         end
      end
      req_valid = '0;
      rsp_ready = '1;
      repeat (6) tick();
      @(negedge clk);
      checkOutput("t6_scoreboard_empty", 32'(sb.size()), 0);
      checkOutput("t6_busy_idle", 32'(busy), 0);
      checkOutput("t6_rsp_idle", 32'(rsp_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
